// File: rtl/pc_vector_sequencer_if.sv
// Bus and PC-control bundle between the instruction decoder/datapath and the
// interrupt/reset entry sequencer.
interface pc_vector_sequencer_if;
    logic        cpu_en;
    logic        int_poll;
    logic        brk_req;
    logic        nmi_n;
    logic        irq_n;
    logic        i_flag;
    logic [15:0] pc;
    logic [7:0]  p;
    logic [7:0]  sp;
    logic        busy;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        mem_write;
    logic        sp_dec;
    logic        set_i;
    logic        pcl_write;
    logic        pch_write;
    logic        pcl_src;
    logic        pch_src;
    logic        done;

    modport master (
        output cpu_en, int_poll, brk_req, nmi_n, irq_n, i_flag, pc, p, sp,
        input  busy, addr, wdata, mem_write, sp_dec, set_i, pcl_write, pch_write,
        input  pcl_src, pch_src, done
    );

    modport slave (
        input  cpu_en, int_poll, brk_req, nmi_n, irq_n, i_flag, pc, p, sp,
        output busy, addr, wdata, mem_write, sp_dec, set_i, pcl_write, pch_write,
        output pcl_src, pch_src, done
    );
endinterface

// File: rtl/pc_vector_sequencer.sv
// 7-cycle 6502 reset/NMI/IRQ/BRK entry: two dummy reads, three stack pushes
// (suppressed on reset), then PCL/PCH loaded from the selected vector.
module pc_vector_sequencer (
    input  logic                 i_clk,
    input  logic                 i_reset,
    pc_vector_sequencer_if.slave io_seq
);
    typedef enum logic [3:0] {
        StRstHold, StIdle, StDum1, StDum2, StPushH, StPushL, StPushP, StVecL, StVecH
    } state_e;

    typedef enum logic [1:0] {KindReset, KindNmi, KindIrq, KindBrk} kind_e;

    state_e      r_state;
    kind_e       r_kind;
    logic        r_b;
    logic [15:0] r_vec;
    logic        r_nmi_prev;
    logic        r_nmi_pending;

    state_e      w_state_d;
    kind_e       w_kind_d;
    logic        w_b_d;
    logic [15:0] w_vec_d;
    logic        w_nmi_pending_d;
    logic        w_nmi_edge;
    logic        w_nmi_clear;
    logic        w_irq_pending;
    logic        w_start;
    logic        w_push_wr;

    logic        w_busy;
    logic [15:0] w_addr;
    logic [7:0]  w_wdata;
    logic        w_mem_write;
    logic        w_sp_dec;
    logic        w_set_i;
    logic        w_pcl_write;
    logic        w_pch_write;
    logic        w_pcl_src;
    logic        w_pch_src;
    logic        w_done;
    logic        w_unused_p;

    assign w_unused_p    = ^io_seq.p[5:4];
    assign w_nmi_edge    = io_seq.cpu_en & r_nmi_prev & ~io_seq.nmi_n;
    assign w_irq_pending = ~io_seq.irq_n & ~io_seq.i_flag;
    assign w_start       = io_seq.cpu_en & io_seq.int_poll
                         & (r_nmi_pending | w_irq_pending | io_seq.brk_req);

    always_comb begin
        w_state_d   = r_state;
        w_kind_d    = r_kind;
        w_b_d       = r_b;
        w_vec_d     = r_vec;
        w_nmi_clear = 1'b0;
        if (io_seq.cpu_en) begin
            unique case (r_state)
                StRstHold: w_state_d = StDum1;
                StIdle: begin
                    if (w_start) begin
                        w_state_d = StDum1;
                        w_kind_d  = r_nmi_pending ? KindNmi :
                                    (w_irq_pending ? KindIrq : KindBrk);
                        w_b_d     = ~r_nmi_pending & ~w_irq_pending;
                    end
                end
                StDum1:  w_state_d = StDum2;
                StDum2:  w_state_d = StPushH;
                StPushH: w_state_d = StPushL;
                StPushL: w_state_d = StPushP;
                StPushP: begin
                    // A pending NMI hijacks whatever sequence is in flight.
                    w_state_d = StVecL;
                    w_vec_d   = r_nmi_pending ? 16'hFFFA :
                                ((r_kind == KindReset) ? 16'hFFFC : 16'hFFFE);
                end
                StVecL: begin
                    w_state_d   = StVecH;
                    w_nmi_clear = (r_vec == 16'hFFFA);
                end
                StVecH:  w_state_d = StIdle;
                default: w_state_d = StRstHold;
            endcase
        end
        // A fresh edge outranks the clear so a back-to-back NMI is not lost.
        w_nmi_pending_d = w_nmi_edge ? 1'b1 : (w_nmi_clear ? 1'b0 : r_nmi_pending);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= StRstHold;
            r_kind        <= KindReset;
            r_b           <= 1'b0;
            r_vec         <= 16'hFFFC;
            r_nmi_prev    <= 1'b1;
            r_nmi_pending <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_kind        <= w_kind_d;
            r_b           <= w_b_d;
            r_vec         <= w_vec_d;
            r_nmi_pending <= w_nmi_pending_d;
            if (io_seq.cpu_en) begin
                r_nmi_prev <= io_seq.nmi_n;
            end
        end
    end

    assign w_push_wr = io_seq.cpu_en & (r_kind != KindReset);

    always_comb begin
        w_busy      = (r_state != StIdle);
        w_addr      = 16'h0000;
        w_wdata     = 8'h00;
        w_mem_write = 1'b0;
        w_sp_dec    = 1'b0;
        w_set_i     = 1'b0;
        w_pcl_write = 1'b0;
        w_pch_write = 1'b0;
        w_pcl_src   = 1'b0;
        w_pch_src   = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            StDum1, StDum2: w_addr = io_seq.pc;
            StPushH, StPushL, StPushP: begin
                w_addr      = {8'h01, io_seq.sp};
                w_mem_write = w_push_wr;
                w_sp_dec    = io_seq.cpu_en;
                if (r_state == StPushH) begin
                    w_wdata = io_seq.pc[15:8];
                end else if (r_state == StPushL) begin
                    w_wdata = io_seq.pc[7:0];
                end else begin
                    w_wdata = {io_seq.p[7:6], 1'b1, r_b, io_seq.p[3:0]};
                end
            end
            StVecL: begin
                w_addr      = r_vec;
                w_pcl_write = io_seq.cpu_en;
                w_pcl_src   = 1'b1;
                w_set_i     = io_seq.cpu_en;
            end
            StVecH: begin
                w_addr      = r_vec + 16'd1;
                w_pch_write = io_seq.cpu_en;
                w_pch_src   = 1'b1;
                w_done      = io_seq.cpu_en;
            end
            default: ;
        endcase
    end

    assign io_seq.busy      = w_busy;
    assign io_seq.addr      = w_addr;
    assign io_seq.wdata     = w_wdata;
    assign io_seq.mem_write = w_mem_write;
    assign io_seq.sp_dec    = w_sp_dec;
    assign io_seq.set_i     = w_set_i;
    assign io_seq.pcl_write = w_pcl_write;
    assign io_seq.pch_write = w_pch_write;
    assign io_seq.pcl_src   = w_pcl_src;
    assign io_seq.pch_src   = w_pch_src;
    assign io_seq.done      = w_done;
endmodule

// File: tb/tb_pc_vector_sequencer.sv
// Bench for pc_vector_sequencer: a small PC/SP/P/stack datapath driven by the
// DUT strobes, a beat-indexed reference model, directed scenarios and random traffic.
module tb_pc_vector_sequencer;
    logic clk;
    logic reset;

    pc_vector_sequencer_if bus ();

    pc_vector_sequencer dut (
        .i_clk  (clk),
        .i_reset(reset),
        .io_seq (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Datapath: registers and memories the sequencer steers.
    logic [15:0] pc_q;
    logic [7:0]  sp_q;
    logic [7:0]  p_q;
    logic [7:0]  stk [0:255];
    logic [7:0]  vec_rom [0:7];
    int          wr_cnt = 0;
    logic        ld_req;
    logic [15:0] ld_pc;
    logic [7:0]  ld_sp;
    logic [7:0]  ld_p;

    assign bus.pc     = pc_q;
    assign bus.sp     = sp_q;
    assign bus.p      = p_q;
    assign bus.i_flag = p_q[2];

    always @(posedge clk) begin
        if (ld_req) begin
            pc_q <= ld_pc;
            sp_q <= ld_sp;
            p_q  <= ld_p;
        end else begin
            if (bus.mem_write) begin
                stk[bus.addr[7:0]] <= bus.wdata;
                wr_cnt <= wr_cnt + 1;
            end
            if (bus.sp_dec) sp_q <= sp_q - 8'd1;
            if (bus.set_i) p_q[2] <= 1'b1;
            if (bus.pcl_write && bus.pcl_src) pc_q[7:0] <= vec_rom[bus.addr[2:0]];
            if (bus.pch_write && bus.pch_src) pc_q[15:8] <= vec_rom[bus.addr[2:0]];
        end
    end

    // Reference model: mode 0 = reset hold, 1 = idle, 2 = running beat 0..6.
    int          m_mode;
    int          m_beat;
    logic        m_rk;
    logic        m_b;
    logic        m_prev;
    logic        m_pend;
    logic        started = 1'b0;
    logic [15:0] m_vec;
    logic [15:0] pc0;
    logic [7:0]  sp0;
    logic [7:0]  p0;

    always @(posedge clk) begin
        if (reset) begin
            started <= 1'b1;
            m_mode  <= 0;
            m_beat  <= 0;
            m_prev  <= 1'b1;
            m_pend  <= 1'b0;
            m_rk    <= 1'b1;
            m_b     <= 1'b0;
        end else if (bus.cpu_en) begin
            m_prev <= bus.nmi_n;
            if (m_prev && !bus.nmi_n) m_pend <= 1'b1;
            else if (m_mode == 2 && m_beat == 5 && m_vec == 16'hFFFA) m_pend <= 1'b0;
            if (m_mode == 0 || (m_mode == 1 && bus.int_poll &&
                    (m_pend || (!bus.irq_n && !p_q[2]) || bus.brk_req))) begin
                m_rk   <= (m_mode == 0);
                m_b    <= (m_mode == 1) && !m_pend && !(!bus.irq_n && !p_q[2]);
                m_mode <= 2;
                m_beat <= 0;
                pc0    <= pc_q;
                sp0    <= sp_q;
                p0     <= p_q;
            end else if (m_mode == 2) begin
                if (m_beat == 4) m_vec <= m_pend ? 16'hFFFA : (m_rk ? 16'hFFFC : 16'hFFFE);
                if (m_beat == 6) m_mode <= 1;
                else m_beat <= m_beat + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Strobe order: mem_write sp_dec set_i pcl_write pch_write pcl_src pch_src done.
    always @(negedge clk) begin
        logic        en;
        logic        e_busy;
        logic [15:0] e_addr;
        logic [15:0] m_a;
        logic [7:0]  e_wd;
        logic [7:0]  m_w;
        logic [7:0]  e_str;
        logic [7:0]  a_str;
        if (started) begin
            en     = bus.cpu_en;
            e_busy = (m_mode != 1);
            e_addr = 16'h0000;
            e_wd   = 8'h00;
            e_str  = 8'h00;
            m_a    = 16'hFFFF;
            m_w    = 8'hFF;
            if (m_mode == 1) begin
                m_a = 16'h0000;
                m_w = 8'h00;
            end else if (m_mode == 2) begin
                m_w = 8'h00;
                if (m_beat < 2) begin
                    e_addr = pc0;
                end else if (m_beat < 5) begin
                    e_addr = {8'h01, sp0 - 8'(m_beat - 2)};
                    m_w    = 8'hFF;
                    e_wd   = (m_beat == 2) ? pc0[15:8] :
                             (m_beat == 3) ? pc0[7:0] : {p0[7:6], 1'b1, m_b, p0[3:0]};
                    e_str  = {en && !m_rk, en, 6'b000000};
                end else if (m_beat == 5) begin
                    e_addr = m_vec;
                    e_str  = {1'b0, 1'b0, en, en, 1'b0, 1'b1, 1'b0, 1'b0};
                end else begin
                    e_addr = m_vec + 16'd1;
                    e_str  = {1'b0, 1'b0, 1'b0, 1'b0, en, 1'b0, 1'b1, en};
                end
            end
            a_str = {bus.mem_write, bus.sp_dec, bus.set_i, bus.pcl_write, bus.pch_write,
                     bus.pcl_src, bus.pch_src, bus.done};
            chk("trace", {31'd0, bus.busy, bus.addr & m_a, bus.wdata & m_w, a_str},
                {31'd0, e_busy, e_addr & m_a, e_wd & m_w, e_str});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] lpc, input logic [7:0] lsp, input logic [7:0] lp);
        ld_pc  = lpc;
        ld_sp  = lsp;
        ld_p   = lp;
        ld_req = 1'b1;
        tick();
        ld_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 100) begin
            tick();
            n++;
        end
        if (bus.busy) begin
            total++;
            bad++;
            $display("FAIL %s: busy still 1 after 100 cycles, required 0", name);
        end
    endtask

    task automatic wait_beat(input int b, input string name);
        int n = 0;
        while (!(m_mode == 2 && m_beat == b) && n < 50) begin
            tick();
            n++;
        end
        if (!(m_mode == 2 && m_beat == b)) begin
            total++;
            bad++;
            $display("FAIL %s: beat %0d never reached, required within 50 cycles", name, b);
        end
    endtask

    task automatic start_irq(input logic [15:0] lpc);
        load(lpc, 8'hFF, 8'h20);
        bus.irq_n    = 1'b0;
        bus.int_poll = 1'b1;
        tick();
        bus.int_poll = 1'b0;
    endtask

    initial begin
        int done_at;
        int nbusy;
        int wc;
        reset        = 1'b1;
        bus.cpu_en   = 1'b0;
        bus.int_poll = 1'b0;
        bus.brk_req  = 1'b0;
        bus.nmi_n    = 1'b1;
        bus.irq_n    = 1'b1;
        ld_req       = 1'b0;
        vec_rom[0] = 8'h00; vec_rom[1] = 8'h00;
        vec_rom[2] = 8'h00; vec_rom[3] = 8'h90;
        vec_rom[4] = 8'h34; vec_rom[5] = 8'h12;
        vec_rom[6] = 8'h00; vec_rom[7] = 8'h80;

        load(16'h0000, 8'hFD, 8'h00);
        repeat (3) begin
            bus.cpu_en = 1'($urandom_range(0, 1));
            tick();
        end
        chk("reset_busy", 64'(bus.busy), 64'd1);
        chk("reset_addr", 64'(bus.addr), 64'h0000);
        chk("reset_strobes", 64'({bus.mem_write, bus.sp_dec, bus.set_i, bus.pcl_write,
            bus.pch_write, bus.pcl_src, bus.pch_src, bus.done}), 64'd0);

        // Power-on reset entry.
        bus.cpu_en = 1'b1;
        reset      = 1'b0;
        tick();
        done_at = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.done) done_at = i;
            tick();
        end
        chk("reset_done_cycle", 64'(done_at), 64'd7);
        chk("reset_pc", 64'(pc_q), 64'h1234);
        chk("reset_sp", 64'(sp_q), 64'hFA);
        chk("reset_writes", 64'(wr_cnt), 64'd0);

        // IRQ entry.
        start_irq(16'hC000);
        wait_idle("irq_idle");
        chk("irq_push_h", 64'(stk[8'hFF]), 64'hC0);
        chk("irq_push_l", 64'(stk[8'hFE]), 64'h00);
        chk("irq_push_p", 64'(stk[8'hFD]), 64'h20);
        chk("irq_pc", 64'(pc_q), 64'h8000);
        chk("irq_p", 64'(p_q), 64'h24);

        // Masked IRQ ignored, then BRK.
        load(16'hC100, 8'hFF, 8'h24);
        bus.irq_n    = 1'b0;
        bus.int_poll = 1'b1;
        repeat (4) tick();
        chk("masked_irq_idle", 64'(bus.busy), 64'd0);
        bus.brk_req = 1'b1;
        tick();
        bus.int_poll = 1'b0;
        bus.brk_req  = 1'b0;
        wait_idle("brk_idle");
        chk("brk_push_p", 64'(stk[8'hFD]), 64'h34);
        chk("brk_push_h", 64'(stk[8'hFF]), 64'hC1);
        chk("brk_pc", 64'(pc_q), 64'h8000);

        // NMI hijack of an IRQ sequence during PUSH_L.
        start_irq(16'hC200);
        wait_beat(3, "hijack_push_l");
        bus.nmi_n = 1'b0;
        wait_idle("hijack_idle");
        chk("hijack_pc", 64'(pc_q), 64'h9000);
        chk("hijack_push_p", 64'(stk[8'hFD]), 64'h20);
        chk("hijack_push_h", 64'(stk[8'hFF]), 64'hC2);
        bus.irq_n    = 1'b1;
        bus.int_poll = 1'b1;
        repeat (5) tick();
        chk("nmi_no_retrigger", 64'(bus.busy), 64'd0);
        bus.int_poll = 1'b0;
        bus.nmi_n    = 1'b1;
        tick();

        // Alternating cpu_en stall.
        start_irq(16'hC300);
        bus.cpu_en = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            nbusy++;
            tick();
            bus.cpu_en = ~bus.cpu_en;
        end
        bus.cpu_en = 1'b1;
        tick();
        chk("stall_clocks", 64'(nbusy), 64'd14);
        chk("stall_pc", 64'(pc_q), 64'h8000);
        chk("stall_push_l", 64'(stk[8'hFE]), 64'h00);

        // Reset in PUSH_P, then a full reset entry.
        start_irq(16'hC400);
        wait_beat(4, "midreset_push_p");
        reset = 1'b1;
        tick();
        wc = wr_cnt;
        chk("midreset_busy", 64'(bus.busy), 64'd1);
        chk("midreset_addr", 64'(bus.addr), 64'h0000);
        reset     = 1'b0;
        bus.irq_n = 1'b1;
        tick();
        wait_idle("midreset_idle");
        chk("midreset_writes", 64'(wr_cnt), 64'(wc));
        chk("midreset_pc", 64'(pc_q), 64'h1234);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            ld_req       = 1'b0;
            bus.cpu_en   = ($urandom_range(0, 3) != 0);
            bus.int_poll = ($urandom_range(0, 2) == 0);
            bus.brk_req  = ($urandom_range(0, 3) == 0);
            bus.irq_n    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) bus.nmi_n = ~bus.nmi_n;
            reset = ($urandom_range(0, 199) == 0);
            if (m_mode == 1 && $urandom_range(0, 7) == 0) begin
                bus.int_poll = 1'b0;
                ld_pc  = 16'($urandom);
                ld_sp  = 8'($urandom);
                ld_p   = 8'($urandom);
                ld_req = 1'b1;
            end
            tick();
        end
        ld_req       = 1'b0;
        reset        = 1'b0;
        bus.int_poll = 1'b0;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
